// File: rtl/bayer_quad_packer_if.sv
// bayer_quad_packer_if: raster pixel input stream and Bayer quad output stream
interface bayer_quad_packer_if #(
    parameter int PIX_W = 8
);
    logic               sof;
    logic               phase_row;
    logic               phase_col;
    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [4*PIX_W-1:0] quad_out;
    logic               quad_valid;
    logic               quad_ready;
    logic               frame_done;
    logic               frame_abort;

    modport master (
        output sof, phase_row, phase_col, pix_in, pix_valid, quad_ready,
        input  pix_ready, quad_out, quad_valid, frame_done, frame_abort
    );

    modport slave (
        input  sof, phase_row, phase_col, pix_in, pix_valid, quad_ready,
        output pix_ready, quad_out, quad_valid, frame_done, frame_abort
    );
endinterface

// File: rtl/bayer_quad_packer.sv
// bayer_quad_packer: packs a raster Bayer stream into {R, G1, G2, B} quads per 2x2 cell
module bayer_quad_packer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic              clk,
    input logic              rst,
    bayer_quad_packer_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, EVEN, ODD, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [1:0]         phase_q, phase_d;
    logic [PIX_W-1:0]   hold_q, hold_d;
    logic [4*PIX_W-1:0] quad_q, quad_d;
    logic               qv_q, qv_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [PIX_W-1:0]   line_buf [IMG_W];
    logic               accept, col_wrap, buf_we;
    logic [CW-1:0]      buf_addr;
    logic [PIX_W-1:0]   p00, p01, p10, p11;

    assign bus.pix_ready   = (state_q == IDLE) ? 1'b1 :
                             (state_q == DRAIN) ? 1'b0 : !(qv_q && !bus.quad_ready);
    assign accept          = bus.pix_valid && bus.pix_ready;
    assign col_wrap        = col_q == COL_LAST;
    assign p00             = line_buf[{col_q[CW-1:1], 1'b0}];
    assign p01             = line_buf[col_q];
    assign p10             = hold_q;
    assign p11             = bus.pix_in;
    assign bus.quad_out    = quad_q;
    assign bus.quad_valid  = qv_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        quad_d   = quad_q;
        qv_d     = qv_q && !bus.quad_ready;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        buf_we   = 1'b0;
        buf_addr = col_q;
        if (state_q == DRAIN && qv_q && bus.quad_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        // An accepted sof always restarts the frame; the beat itself is pixel (0,0)
        if (accept && bus.sof) begin
            abort_d  = state_q inside {EVEN, ODD};
            phase_d  = {bus.phase_row, bus.phase_col};
            hold_d   = '0;
            buf_we   = 1'b1;
            buf_addr = '0;
            col_d    = CW'(1);
            row_d    = '0;
            state_d  = EVEN;
        end else if (accept && state_q != IDLE) begin
            col_d = col_wrap ? '0 : col_q + CW'(1);
            if (state_q == EVEN) begin
                buf_we = 1'b1;
                if (col_wrap) begin
                    row_d   = row_q + RW'(1);
                    state_d = ODD;
                end
            end else begin
                if (!col_q[0]) begin
                    hold_d = bus.pix_in;
                end else begin
                    quad_d = (phase_q == 2'b00) ? {p00, p01, p10, p11} :
                             (phase_q == 2'b01) ? {p01, p00, p11, p10} :
                             (phase_q == 2'b10) ? {p10, p00, p11, p01} :
                                                  {p11, p01, p10, p00};
                    qv_d   = 1'b1;
                end
                if (col_wrap) begin
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    state_d = (row_q == ROW_LAST) ? DRAIN : EVEN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            phase_q <= '0;
            hold_q  <= '0;
            quad_q  <= '0;
            qv_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            quad_q  <= quad_d;
            qv_q    <= qv_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) line_buf[buf_addr] <= bus.pix_in;
    end
endmodule

// File: tb/tb_bayer_quad_packer.sv
// tb_bayer_quad_packer: scoreboard bench for the Bayer quad packer on a 4x2 image
module tb_bayer_quad_packer;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bayer_quad_packer_if #(.PIX_W(PIX_W)) bus ();
    bayer_quad_packer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0, errors = 0, n_quads = 0, n_done = 0, n_abort = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic [7:0]  frm [8];

    function automatic logic [31:0] exp_quad(input logic [1:0] ph, input logic [7:0] a, b, c, d);
        case (ph)
            2'b00:   return {a, b, c, d};
            2'b01:   return {b, a, d, c};
            2'b10:   return {c, a, d, b};
            default: return {d, b, c, a};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) n_done++;
            if (bus.frame_abort) n_abort++;
            if (bus.quad_valid && bus.quad_ready) begin
                n_quads++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_quad: got %h, required no quad", bus.quad_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.quad_out !== mon_exp) begin
                        errors++;
                        $display("FAIL quad_data: got %h, required %h", bus.quad_out, mon_exp);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] p, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        bus.pix_in = p;
        bus.sof = s;
        bus.pix_valid = 1'b1;
        while (!bus.pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pix_ready got 0 for 50 cycles, required 1");
        end else begin
            @(posedge clk);
        end
        #1;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] ph, input int lo, input int hi);
        bus.phase_row = ph[1];
        bus.phase_col = ph[0];
        for (int i = lo; i < hi; i++) begin
            if (i == 5) exp_q.push_back(exp_quad(ph, frm[0], frm[1], frm[4], frm[5]));
            if (i == 7) exp_q.push_back(exp_quad(ph, frm[2], frm[3], frm[6], frm[7]));
            send(frm[i], i == 0);
        end
    endtask

    task automatic seq_frame(input int base);
        for (int i = 0; i < 8; i++) frm[i] = 8'(base + i + 1);
    endtask

    task automatic test_reset;
        bus.sof = 0; bus.phase_row = 0; bus.phase_col = 0;
        bus.pix_in = 0; bus.pix_valid = 0; bus.quad_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.quad_valid !== 1'b0) begin errors++; $display("FAIL reset_qvalid: got %b, required 0", bus.quad_valid); end
        if (bus.quad_out !== 32'h0) begin errors++; $display("FAIL reset_qout: got %h, required 0", bus.quad_out); end
        if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b, required 1", bus.pix_ready); end
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.frame_done); end
        if (bus.frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, required 0", bus.frame_abort); end
        rst = 0;
    endtask

    task automatic test_idle_discard;
        int q0;
        q0 = n_quads;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        repeat (4) @(posedge clk);
        checks++;
        if (n_quads !== q0) begin errors++; $display("FAIL idle_discard: got %0d quads, required 0", n_quads - q0); end
    endtask

    task automatic test_phase00;
        int q0, d0;
        q0 = n_quads; d0 = n_done;
        seq_frame(0);
        run_frame(2'b00, 0, 5);
        checks++;
        if (bus.quad_valid !== 1'b0) begin errors++; $display("FAIL early_quad: got %b, required 0", bus.quad_valid); end
        run_frame(2'b00, 5, 6);
        checks++;
        if (bus.quad_valid !== 1'b1 || bus.quad_out !== {8'd1, 8'd2, 8'd5, 8'd6}) begin
            errors++; $display("FAIL quad1_latency: got v=%b %h, required v=1 01020506", bus.quad_valid, bus.quad_out);
        end
        run_frame(2'b00, 6, 8);
        checks++;
        if (bus.quad_valid !== 1'b1 || bus.quad_out !== {8'd3, 8'd4, 8'd7, 8'd8}) begin
            errors++; $display("FAIL quad2_latency: got v=%b %h, required v=1 03040708", bus.quad_valid, bus.quad_out);
        end
        repeat (5) @(posedge clk);
        checks += 2;
        if (n_done !== d0 + 1) begin errors++; $display("FAIL frame_done: got %0d pulses, required 1", n_done - d0); end
        if (n_quads !== q0 + 2) begin errors++; $display("FAIL quad_count: got %0d, required 2", n_quads - q0); end
    endtask

    task automatic test_phases;
        logic [1:0]  phs [3];
        logic [31:0] lit [3];
        phs[0] = 2'b11; lit[0] = {8'd6, 8'd2, 8'd5, 8'd1};
        phs[1] = 2'b01; lit[1] = {8'd2, 8'd1, 8'd6, 8'd5};
        phs[2] = 2'b10; lit[2] = {8'd5, 8'd1, 8'd6, 8'd2};
        for (int k = 0; k < 3; k++) begin
            seq_frame(0);
            run_frame(phs[k], 0, 6);
            checks++;
            if (bus.quad_out !== lit[k]) begin
                errors++; $display("FAIL phase_%b: got %h, required %h", phs[k], bus.quad_out, lit[k]);
            end
            run_frame(phs[k], 6, 8);
            repeat (5) @(posedge clk);
        end
    endtask

    task automatic test_stall;
        int d0;
        d0 = n_done;
        seq_frame(0);
        run_frame(2'b00, 0, 6);
        bus.quad_ready = 0;
        fork
            run_frame(2'b00, 6, 8);
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.quad_valid !== 1'b1 || bus.quad_out !== {8'd1, 8'd2, 8'd5, 8'd6} || bus.pix_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b q=%h rdy=%b, required v=1 q=01020506 rdy=0",
                                 bus.quad_valid, bus.quad_out, bus.pix_ready);
                    end
                end
                bus.quad_ready = 1;
            end
        join
        checks++;
        if (bus.quad_out !== {8'd3, 8'd4, 8'd7, 8'd8}) begin
            errors++; $display("FAIL stall_quad2: got %h, required 03040708", bus.quad_out);
        end
        repeat (5) @(posedge clk);
        checks++;
        if (n_done !== d0 + 1) begin errors++; $display("FAIL stall_done: got %0d, required 1", n_done - d0); end
    endtask

    task automatic test_abort;
        int q0, d0, a0;
        q0 = n_quads; d0 = n_done; a0 = n_abort;
        seq_frame(0);
        run_frame(2'b00, 0, 5);
        seq_frame(10);
        run_frame(2'b10, 0, 1);
        checks++;
        if (bus.frame_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b, required 1", bus.frame_abort); end
        run_frame(2'b10, 1, 8);
        repeat (5) @(posedge clk);
        checks += 3;
        if (n_abort !== a0 + 1) begin errors++; $display("FAIL abort_count: got %0d, required 1", n_abort - a0); end
        if (n_done !== d0 + 1) begin errors++; $display("FAIL abort_done: got %0d, required 1", n_done - d0); end
        if (n_quads !== q0 + 2) begin errors++; $display("FAIL abort_quads: got %0d, required 2", n_quads - q0); end
    endtask

    task automatic test_abort_pending;
        int q0, a0;
        q0 = n_quads; a0 = n_abort;
        seq_frame(20);
        run_frame(2'b01, 0, 6);
        seq_frame(30);
        run_frame(2'b00, 0, 8);
        repeat (5) @(posedge clk);
        checks += 2;
        if (n_abort !== a0 + 1) begin errors++; $display("FAIL pend_abort: got %0d, required 1", n_abort - a0); end
        if (n_quads !== q0 + 3) begin errors++; $display("FAIL pend_quads: got %0d, required 3", n_quads - q0); end
    endtask

    task automatic test_back_to_back;
        int q0, d0;
        logic [1:0] ph;
        q0 = n_quads; d0 = n_done;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) frm[i] = 8'($urandom);
            ph = 2'($urandom);
            run_frame(ph, 0, 8);
        end
        repeat (5) @(posedge clk);
        checks += 2;
        if (n_done !== d0 + 3) begin errors++; $display("FAIL b2b_done: got %0d, required 3", n_done - d0); end
        if (n_quads !== q0 + 6) begin errors++; $display("FAIL b2b_quads: got %0d, required 6", n_quads - q0); end
    endtask

    task automatic test_reset_mid;
        int q0;
        seq_frame(40);
        run_frame(2'b00, 0, 5);
        send(frm[5], 1'b0);
        checks++;
        if (bus.quad_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b, required 1", bus.quad_valid); end
        rst = 1;
        #1;
        checks += 2;
        if (bus.quad_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_qvalid: got %b, required 0", bus.quad_valid); end
        if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_pready: got %b, required 1", bus.pix_ready); end
        @(posedge clk);
        #1;
        rst = 0;
        q0 = n_quads;
        for (int i = 0; i < 8; i++) send(8'(50 + i), 1'b0);
        repeat (4) @(posedge clk);
        checks++;
        if (n_quads !== q0) begin errors++; $display("FAIL post_rst_quads: got %0d, required 0", n_quads - q0); end
    endtask

    initial begin
        test_reset;
        test_idle_discard;
        test_phase00;
        test_phases;
        test_stall;
        test_abort;
        test_abort_pending;
        test_back_to_back;
        test_reset_mid;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
